dvsd_cmp_bist: RTL and testbench

Synthesizable self-test driver/checker for the 4-bit magnitude comparator `dvsd_cmp`: it generates the comparator's `A_in`/`B_in` operands and checks its `less_than`/`equal_to`/`greater_than` results. On `start` it sweeps every operand pair exhaustively, compares each DUT result against an internally computed golden result, and reports pass/fail, an error count and the first failing vector. It sits beside the comparator in the harden/sign-off flow so the comparator can be checked in gate-level simulation and on silicon without an external pattern source.

---
 rtl/dvsd_cmp_bist_if.sv | 24 ++
 rtl/dvsd_cmp_bist.sv | 130 +++++++++++++
 tb/tb_dvsd_cmp_bist.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dvsd_cmp_bist_if.sv
// Operand/result bus between the comparator BIST engine and the comparator under test.
// Latency: none, plain wires; operands come from BIST registers, results are combinational.
// Backpressure: none, the BIST paces vectors with its own settle counter.
interface dvsd_cmp_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A_out;
  logic [WIDTH-1:0] B_out;
  logic             less_than;
  logic             equal_to;
  logic             greater_than;

  // BIST side drives operands and observes results.
  modport master (
    output A_out, B_out,
    input  less_than, equal_to, greater_than
  );

  // Comparator side consumes operands and returns results.
  modport slave (
    input  A_out, B_out,
    output less_than, equal_to, greater_than
  );
endinterface

// File: rtl/dvsd_cmp_bist.sv
// Exhaustive self-test driver/checker for the magnitude comparator: sweeps all operand pairs, checks against golden.
// Latency: SETTLE+1 cycles per vector, done pulses 1+2^(2*WIDTH)*(SETTLE+1) cycles after an accepted start.
// Backpressure: none; start is only sampled in IDLE, anything else is dropped.
module dvsd_cmp_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  dvsd_cmp_bist_if.master      cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2:0]           fail_res
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2*WIDTH:0]   ERR_MAX     = '1;
  localparam logic [2*WIDTH:0]   ERR_ONE     = 1;
  localparam logic [2*WIDTH-1:0] VEC_ONE     = 1;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] vec;
  logic [3:0]         settle_cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2:0]         obs;
  logic [2:0]         gold;
  logic               mismatch;
  logic               last_vec;
  logic               settle_end;

  // The vector counter doubles as the operand register, so A/B hold the last pair after a sweep.
  assign op_a      = vec[2*WIDTH-1:WIDTH];
  assign op_b      = vec[WIDTH-1:0];
  assign cmp.A_out = op_a;
  assign cmp.B_out = op_b;

  // Any bit differing from the unsigned golden compare is an error, which also flags non-one-hot results.
  assign obs        = {cmp.less_than, cmp.equal_to, cmp.greater_than};
  assign gold       = {op_a < op_b, op_a == op_b, op_a > op_b};
  assign mismatch   = (obs != gold);
  assign last_vec   = &vec;
  assign settle_end = (settle_cnt == SETTLE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: settle for SETTLE cycles, sample once, advance until the all-ones vector.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_DRIVE;
      ST_DRIVE:  if (settle_end) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath: vector/settle counters, error accounting and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_res   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_res   <= '0;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= settle_end ? 4'd0 : settle_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= op_a;
              fail_b     <= op_b;
              fail_res   <= obs;
            end
          end
          // Pass is resolved here, including this last vector, so it is already valid alongside done.
          if (last_vec) pass <= (err_count == '0) && !mismatch;
          else          vec  <= vec + VEC_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dvsd_cmp_bist.sv
// Directed bench for dvsd_cmp_bist with a behavioural comparator that can inject faults.
// Latency: checks done timing against the sweep length for SETTLE=1 and SETTLE=3.
// Backpressure: n/a.
module tb_dvsd_cmp_bist;

  logic clk;
  logic rst;
  logic start1;
  logic start3;
  int   fault;     // 0 good, 1 gt stuck 0, 2 lt/gt swapped, 3 eq stuck 1
  int   tests  = 0;
  int   failed = 0;

  dvsd_cmp_bist_if #(.WIDTH(4)) cmp1 ();
  dvsd_cmp_bist_if #(.WIDTH(4)) cmp3 ();

  logic       busy1, done1, pass1, fv1;
  logic [8:0] err1;
  logic [3:0] fa1, fb1;
  logic [2:0] fres1;
  logic       busy3, done3, pass3, fv3;
  logic [8:0] err3;
  logic [3:0] fa3, fb3;
  logic [2:0] fres3;

  dvsd_cmp_bist #(.WIDTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmp(cmp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_res(fres1)
  );

  dvsd_cmp_bist #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cmp(cmp3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3), .fail_res(fres3)
  );

  function automatic logic [2:0] cmp_model(input logic [3:0] a, input logic [3:0] b, input int f);
    logic lt, eq, gt;
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
    case (f)
      1:       return {lt, eq, 1'b0};
      2:       return {gt, eq, lt};
      3:       return {lt, 1'b1, gt};
      default: return {lt, eq, gt};
    endcase
  endfunction

  assign {cmp1.less_than, cmp1.equal_to, cmp1.greater_than} = cmp_model(cmp1.A_out, cmp1.B_out, fault);
  assign {cmp3.less_than, cmp3.equal_to, cmp3.greater_than} = cmp_model(cmp3.A_out, cmp3.B_out, 0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulses start1 for one cycle, optionally re-pulses it mid-sweep, and returns cycles to done.
  task automatic run_sweep1(input int restart_at, output int lat);
    lat = -1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("accept_busy", busy1, 1);
    chk("accept_a", cmp1.A_out, 0);
    chk("accept_b", cmp1.B_out, 0);
    for (int n = 1; n <= 3000; n++) begin
      if (done1) begin
        lat = n;
        break;
      end
      @(negedge clk);
      if (n + 1 == restart_at)      start1 = 1'b1;
      else if (n == restart_at)     start1 = 1'b0;
    end
    start1 = 1'b0;
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pass"}, pass1, 0);
    chk({tag, "_err"},  err1, 0);
    chk({tag, "_fv"},   fv1, 0);
    chk({tag, "_fail"}, {fa1, fb1, fres1}, 0);
    chk({tag, "_ab"},   {cmp1.A_out, cmp1.B_out}, 0);
  endtask

  typedef struct {
    int         fault;
    int         err;
    logic       pass;
    logic       fv;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [2:0] fres;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat;
    int changes;
    int bad;
    int last_chg;
    logic [7:0] prev;
    logic [7:0] cur;

    tbl[0] = '{fault: 0, err: 0,   pass: 1'b1, fv: 1'b0, fa: 4'd0, fb: 4'd0, fres: 3'b000};
    tbl[1] = '{fault: 1, err: 120, pass: 1'b0, fv: 1'b1, fa: 4'd1, fb: 4'd0, fres: 3'b000};
    tbl[2] = '{fault: 2, err: 240, pass: 1'b0, fv: 1'b1, fa: 4'd0, fb: 4'd1, fres: 3'b001};
    tbl[3] = '{fault: 3, err: 240, pass: 1'b0, fv: 1'b1, fa: 4'd0, fb: 4'd1, fres: 3'b110};

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; fault = 0;
    repeat (3) @(negedge clk);
    chk_reset1("reset");
    chk("reset3_state", {busy3, done3, pass3, err3, fv3, fa3, fb3, fres3}, 0);

    // Reset and start on the same edge: start must be dropped.
    start1 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0;
    chk("rst_start_busy", busy1, 0);
    @(negedge clk);
    chk("rst_start_idle", busy1, 0);

    // Fault table, one full sweep per entry.
    for (int i = 0; i < 4; i++) begin
      fault = tbl[i].fault;
      run_sweep1(0, lat);
      chk("done_latency", lat, 513);
      chk("pass", pass1, tbl[i].pass);
      chk("err_count", err1, tbl[i].err);
      chk("fail_valid", fv1, tbl[i].fv);
      chk("fail_a", fa1, tbl[i].fa);
      chk("fail_b", fb1, tbl[i].fb);
      chk("fail_res", fres1, tbl[i].fres);
      chk("done_busy", busy1, 1);
      @(negedge clk);
      chk("post_done", done1, 0);
      chk("post_busy", busy1, 0);
      chk("hold_ab", {cmp1.A_out, cmp1.B_out}, 8'hff);
      chk("hold_pass", pass1, tbl[i].pass);
    end

    // Reset 100 cycles into a sweep abandons it; a fresh sweep then passes.
    fault = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_busy", busy1, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset1("midrst");
    run_sweep1(0, lat);
    chk("after_rst_latency", lat, 513);
    chk("after_rst_pass", pass1, 1);

    // A second start 50 cycles in is ignored.
    @(negedge clk);
    run_sweep1(50, lat);
    chk("restart_latency", lat, 513);
    chk("restart_pass", pass1, 1);
    @(negedge clk);
    chk("restart_idle", busy1, 0);

    // Held start: exactly one IDLE cycle between done and the next DRIVE.
    start1 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (done1) begin
        lat = n;
        break;
      end
    end
    chk("b2b_done_seen", (lat > 0), 1);
    @(negedge clk);
    chk("b2b_idle", busy1, 0);
    @(negedge clk);
    chk("b2b_redrive", busy1, 1);
    chk("b2b_ab", {cmp1.A_out, cmp1.B_out}, 0);
    start1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // SETTLE=3: 1025-cycle sweep, each operand pair held 4 cycles.
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    lat = -1; changes = 0; bad = 0; last_chg = 1;
    prev = {cmp3.A_out, cmp3.B_out};
    for (int n = 1; n <= 3000; n++) begin
      cur = {cmp3.A_out, cmp3.B_out};
      if (cur != prev) begin
        changes++;
        if (n - last_chg != 4) bad++;
        last_chg = n;
        prev = cur;
      end
      if (done3) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk("settle3_latency", lat, 1025);
    chk("settle3_pass", pass3, 1);
    chk("settle3_err", err3, 0);
    chk("settle3_changes", changes, 255);
    chk("settle3_stable4", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
